// File: rtl/juice_press.sv
// Multi-channel fruit accumulator: weighted adds into a bowl that pours over
// a valid/ready handshake when it reaches CAP or a pour is requested.
module juice_press #(
  parameter int N_FRUIT  = 4,
  parameter int SEL_W    = $clog2(N_FRUIT),
  parameter int WIDTH    = 8,
  parameter int INIT     = 5,
  parameter int CAP      = 200,
  parameter int SATURATE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fruit_en,
  input  logic [SEL_W-1:0]   sel,
  input  logic [N_FRUIT-1:0] fruit,
  input  logic [WIDTH-1:0]   water,
  input  logic               pour_req,
  output logic               juice_valid,
  input  logic               juice_ready,
  output logic [WIDTH-1:0]   juice,
  output logic [WIDTH-1:0]   level,
  output logic               spill
);

  typedef enum logic {FILL, POUR} state_t;

  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] CAP_V  = WIDTH'(CAP);

  state_t           state_p1, state_nxt;
  logic [WIDTH-1:0] bowl_p1, bowl_nxt;
  logic             spill_p1, spill_nxt;
  logic             sel_bit;
  logic             hit;
  logic [WIDTH-1:0] add;
  logic [WIDTH-1:0] sum_res;

  function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[WIDTH] && (SATURATE != 0)) return '1;
    return s[WIDTH-1:0];
  endfunction

  // Only in-range selects can match, so sel >= N_FRUIT yields no fruit.
  always_comb begin
    sel_bit = 1'b0;
    for (int i = 0; i < N_FRUIT; i++) begin
      if (sel == SEL_W'(i)) sel_bit = fruit[i];
    end
  end

  assign hit     = fruit_en & sel_bit;
  assign add     = hit ? water : '0;
  assign sum_res = sat_add(bowl_p1, add);

  always_comb begin
    state_nxt = state_p1;
    bowl_nxt  = bowl_p1;
    spill_nxt = 1'b0;
    case (state_p1)
      FILL: begin
        bowl_nxt = sum_res;
        if ((sum_res >= CAP_V) || pour_req) state_nxt = POUR;
      end
      POUR: begin
        spill_nxt = hit;
        if (juice_ready) begin
          state_nxt = FILL;
          bowl_nxt  = INIT_V;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // Stage p1: bowl, state and spill registers drive all outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1 <= FILL;
      bowl_p1  <= INIT_V;
      spill_p1 <= 1'b0;
    end else begin
      state_p1 <= state_nxt;
      bowl_p1  <= bowl_nxt;
      spill_p1 <= spill_nxt;
    end
  end

  assign juice_valid = (state_p1 == POUR);
  assign juice       = bowl_p1;
  assign level       = bowl_p1;
  assign spill       = spill_p1;

endmodule

// File: tb/tb_juice_press.sv
// Directed scoreboard bench for juice_press: default build plus wrap and
// saturate builds with CAP=255.
module tb_juice_press;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_fe, a_pr, a_rdy;
  logic [2:0] a_sel;
  logic [3:0] a_fruit;
  logic [7:0] a_water;
  logic       a_valid, a_spill;
  logic [7:0] a_juice, a_level;

  logic       b_fe, b_pr, b_rdy;
  logic [2:0] b_sel;
  logic [3:0] b_fruit;
  logic [7:0] b_water;
  logic       w_valid, w_spill, s_valid, s_spill;
  logic [7:0] w_juice, w_level, s_juice, s_level;

  juice_press #(.N_FRUIT(4), .SEL_W(3), .WIDTH(8), .INIT(5), .CAP(200), .SATURATE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .fruit_en(a_fe), .sel(a_sel), .fruit(a_fruit),
    .water(a_water), .pour_req(a_pr), .juice_valid(a_valid), .juice_ready(a_rdy),
    .juice(a_juice), .level(a_level), .spill(a_spill));

  juice_press #(.N_FRUIT(4), .SEL_W(3), .WIDTH(8), .INIT(5), .CAP(255), .SATURATE(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .fruit_en(b_fe), .sel(b_sel), .fruit(b_fruit),
    .water(b_water), .pour_req(b_pr), .juice_valid(w_valid), .juice_ready(b_rdy),
    .juice(w_juice), .level(w_level), .spill(w_spill));

  juice_press #(.N_FRUIT(4), .SEL_W(3), .WIDTH(8), .INIT(5), .CAP(255), .SATURATE(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .fruit_en(b_fe), .sel(b_sel), .fruit(b_fruit),
    .water(b_water), .pour_req(b_pr), .juice_valid(s_valid), .juice_ready(b_rdy),
    .juice(s_juice), .level(s_level), .spill(s_spill));

  typedef struct {
    logic [7:0] lvl;
    logic       vld;
    logic       spl;
    string      tag;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic cmp(input exp_t e, input logic [7:0] lvl, input logic [7:0] jc,
                     input logic vld, input logic spl);
    chk({e.tag, ".level"}, lvl, e.lvl);
    chk({e.tag, ".juice"}, jc, e.lvl);
    chk({e.tag, ".valid"}, {7'd0, vld}, {7'd0, e.vld});
    chk({e.tag, ".spill"}, {7'd0, spl}, {7'd0, e.spl});
  endtask

  task automatic pop_check(input logic [7:0] lvl, input logic [7:0] jc,
                           input logic vld, input logic spl);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sbq.pop_front();
      cmp(e, lvl, jc, vld, spl);
    end
  endtask

  task automatic step_a(input string tag, input logic fe, input logic [2:0] s,
                        input logic [3:0] f, input logic [7:0] w, input logic pr,
                        input logic rdy, input logic [7:0] el, input logic ev,
                        input logic es);
    exp_t e;
    @(negedge clk);
    a_fe = fe; a_sel = s; a_fruit = f; a_water = w; a_pr = pr; a_rdy = rdy;
    e.lvl = el; e.vld = ev; e.spl = es; e.tag = tag;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    pop_check(a_level, a_juice, a_valid, a_spill);
  endtask

  task automatic step_bc(input string tag, input logic [7:0] w,
                         input logic [7:0] wl, input logic wv,
                         input logic [7:0] sl, input logic sv);
    exp_t e;
    @(negedge clk);
    b_fe = 1'b1; b_sel = 3'd0; b_fruit = 4'b0001; b_water = w; b_pr = 1'b0; b_rdy = 1'b0;
    e.lvl = wl; e.vld = wv; e.spl = 1'b0; e.tag = {tag, "_wrap"};
    sbq.push_back(e);
    e.lvl = sl; e.vld = sv; e.spl = 1'b0; e.tag = {tag, "_sat"};
    sbq.push_back(e);
    @(posedge clk);
    #1;
    pop_check(w_level, w_juice, w_valid, w_spill);
    pop_check(s_level, s_juice, s_valid, s_spill);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    a_fe = 0; a_sel = 0; a_fruit = 0; a_water = 0; a_pr = 0; a_rdy = 0;
    b_fe = 0; b_sel = 0; b_fruit = 0; b_water = 0; b_pr = 0; b_rdy = 0;
    repeat (3) @(posedge clk);
    #1;
    e.lvl = 8'd5; e.vld = 1'b0; e.spl = 1'b0; e.tag = "reset";
    cmp(e, a_level, a_juice, a_valid, a_spill);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic accumulation on channel 2.
    step_a("fill1", 1, 3'd2, 4'b0100, 8'd10, 0, 0, 8'd15, 0, 0);
    step_a("fill2", 1, 3'd2, 4'b0100, 8'd10, 0, 0, 8'd25, 0, 0);
    step_a("fill3", 1, 3'd2, 4'b0100, 8'd10, 0, 0, 8'd35, 0, 0);
    step_a("fill_absent", 1, 3'd1, 4'b0100, 8'd10, 0, 0, 8'd35, 0, 0);
    step_a("sel_oob", 1, 3'd5, 4'hF, 8'd10, 0, 0, 8'd35, 0, 0);
    step_a("no_en", 0, 3'd2, 4'hF, 8'd10, 0, 0, 8'd35, 0, 0);
    // Forced pour with a concurrent hit: add first, then pour.
    step_a("req_hit", 1, 3'd2, 4'b0100, 8'd3, 1, 0, 8'd38, 1, 0);
    step_a("req_hold", 0, 3'd0, 4'h0, 8'd0, 0, 0, 8'd38, 1, 0);
    step_a("req_hs", 0, 3'd0, 4'h0, 8'd0, 0, 1, 8'd5, 0, 0);
    // Threshold crossing.
    step_a("cap1", 1, 3'd2, 4'b0100, 8'd50, 0, 0, 8'd55, 0, 0);
    step_a("cap2", 1, 3'd2, 4'b0100, 8'd50, 0, 0, 8'd105, 0, 0);
    step_a("cap3", 1, 3'd2, 4'b0100, 8'd50, 0, 0, 8'd155, 0, 0);
    step_a("cap4", 1, 3'd2, 4'b0100, 8'd50, 0, 0, 8'd205, 1, 0);
    // Backpressure with fruit arriving: juice frozen, spill pulses.
    for (int i = 0; i < 5; i++)
      step_a("bp_spill", 1, 3'd2, 4'b0100, 8'd50, 0, 0, 8'd205, 1, 1);
    step_a("bp_quiet", 0, 3'd2, 4'b0100, 8'd50, 1, 0, 8'd205, 1, 0);
    step_a("hs_spill", 1, 3'd2, 4'b0100, 8'd50, 0, 1, 8'd5, 0, 1);
    // Back-to-back pour request right after the handshake.
    step_a("b2b_req", 0, 3'd0, 4'h0, 8'd0, 1, 0, 8'd5, 1, 0);
    step_a("b2b_hs", 0, 3'd0, 4'h0, 8'd0, 0, 1, 8'd5, 0, 0);
    // Reach POUR, then assert reset between edges.
    for (int i = 1; i <= 4; i++)
      step_a("refill", 1, 3'd3, 4'b1000, 8'd50, 0, 0, 8'(5 + 50 * i), (i == 4), 0);
    @(negedge clk);
    a_fe = 0; a_pr = 0; a_rdy = 0;
    #2;
    rst_n = 1'b0;
    #1;
    e.lvl = 8'd5; e.vld = 1'b0; e.spl = 1'b0; e.tag = "async_rst";
    cmp(e, a_level, a_juice, a_valid, a_spill);
    @(negedge clk);
    rst_n = 1'b1;
    step_a("post_rst", 1, 3'd0, 4'b0001, 8'd10, 0, 0, 8'd15, 0, 0);

    // Wrap versus saturate near the top of the range.
    step_bc("to250", 8'd245, 8'd250, 0, 8'd250, 0);
    step_bc("over", 8'd10, 8'd4, 0, 8'd255, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/juice_press.md
# juice_press

Parametrised multi-channel successor to the single-bit fruit accumulator. It selects one of N fruit inputs per cycle, adds a weighted amount into a WIDTH-bit bowl with selectable saturate/wrap arithmetic, and pours the bowl downstream over a valid/ready handshake once a capacity threshold is reached or a pour is requested. It sits between the fruit-source logic and any juice consumer that can apply backpressure.

## Interface
- N_FRUIT, 4: number of fruit input channels (≥2).
- SEL_W, $clog2(N_FRUIT): width of the channel select.
- WIDTH, 8: bowl, water and juice width.
- INIT, 5: bowl value after reset and after every pour (< CAP).
- CAP, 200: pour threshold; pour when bowl ≥ CAP (CAP ≤ 2^WIDTH−1).
- SATURATE, 1: 1 = clamp sum at 2^WIDTH−1, 0 = wrap modulo 2^WIDTH.

- clk  in  1  clock, rising edge.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- fruit_en  in  1  fruit sample valid this cycle.
- sel  in  SEL_W  channel select; values ≥ N_FRUIT select no fruit.
- fruit  in  N_FRUIT  per-channel fruit present bits.
- water  in  WIDTH  amount added when the selected fruit is present.
- pour_req  in  1  force a pour regardless of level (single-cycle pulse).
- juice_valid  out  1  poured juice available.
- juice_ready  in  1  consumer accepts juice.
- juice  out  WIDTH  bowl contents; stable while juice_valid.
- level  out  WIDTH  current bowl value (always equals juice).
- spill  out  1  registered one-cycle pulse: fruit arrived while pouring and was dropped.

## Operation
- States: FILL, POUR. Reset → FILL.
- hit = fruit_en & (sel < N_FRUIT) & fruit[sel]; add = hit ? water : 0.
- FILL: sum = bowl + add computed WIDTH+1 bits. Overflow: SATURATE=1 → 2^WIDTH−1; SATURATE=0 → low WIDTH bits. bowl ← result.
- FILL → POUR at the same edge when result ≥ CAP, or pour_req=1 (pour_req and hit in the same cycle: add first, then pour).
- POUR: juice_valid=1, bowl frozen, fruit ignored. hit in POUR → spill=1 next cycle. pour_req in POUR ignored.
- POUR → FILL on the edge where juice_valid & juice_ready; bowl ← INIT. Fruit in that handshake cycle is dropped (spill pulses).
- With SATURATE=0 a wrapped result below CAP does not pour (documented wrap behaviour).
- juice_valid never deasserts without a handshake except via reset.

## Timing
- Reset (async assert, sync-released by upstream): bowl=INIT, state=FILL, juice_valid=0, spill=0, juice=level=INIT.
- Reset mid-POUR: juice_valid drops immediately; pending juice is lost.
- Latency: hit at edge k → level updated after edge k; if threshold crossed, juice_valid=1 in the same cycle as the new level (1-cycle fruit-to-valid).
- Handshake completes at edge; juice_valid=0 and level=INIT in the following cycle. Minimum pour interval 1 cycle in POUR.
- Back-to-back: pour_req in the cycle after handshake is honoured (FILL); with level=INIT this pours INIT.
- All outputs registered; no combinational path input → output.

## Test plan
- Reset then fruit_en=1, sel=2, fruit=4'b0100, water=10 for 3 cycles → level 15, 25, 35; juice_valid=0.
- CAP=200, INIT=5, water=50, sel on present channel for 4 cycles → level 55,105,155,205; juice_valid=1 with juice=205; juice_ready=1 → next cycle level=5, juice_valid=0.
- In POUR, hold juice_ready=0 for 5 cycles with fruit hits → juice stable at 205, spill pulses each following cycle, level unchanged.
- SATURATE=0, WIDTH=8, CAP=255, level=250, water=10 → level=4, no pour; SATURATE=1 same stimulus → level=255, juice_valid=1.
- sel=5 with N_FRUIT=4, fruit=4'hF → level unchanged; then pour_req=1 at level 35 with concurrent hit water=3 → juice=38, juice_valid=1.
- Deassert rst_n mid-POUR between clock edges → juice_valid=0 and level=INIT immediately, before the next edge.
